// File: rtl/silife_sequencer_pkg.sv
// Shared types and constants for the silife sequencer.
package silife_sequencer_pkg;

  // Controller states: waiting, applying one host row write, firing one generation step.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_STEP  = 2'd2
  } seq_state_t;

  localparam int DEF_PERIOD_BITS = 16;
  localparam int DEF_GEN_BITS    = 16;

  // Row index width for a matrix of the given height (never narrower than one bit).
  function automatic int row_bits(input int height);
    return (height <= 2) ? 1 : $clog2(height);
  endfunction

endpackage

// File: rtl/silife_step_timer.sv
// Free-running step timer: counts cycles while run is high and flags when the
// programmed interval has elapsed. A period of 0 behaves like a period of 1.
module silife_step_timer
  import silife_sequencer_pkg::*;
#(
  parameter int PERIOD_BITS = DEF_PERIOD_BITS
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic                   count_en,
  input  logic                   issue,
  input  logic [PERIOD_BITS-1:0] period,
  output logic                   due
);

  localparam logic [PERIOD_BITS-1:0] ONE = PERIOD_BITS'(1);

  logic [PERIOD_BITS-1:0] timer;
  logic [PERIOD_BITS-1:0] limit_m1;

  assign limit_m1 = (period == '0) ? '0 : (period - ONE);

  // Due stays up while the interval has elapsed; run low drops it at once.
  assign due = run && (timer >= limit_m1);

  // Count IDLE/WRITE cycles. On issue the timer restarts at 1 because the
  // STEP cycle that follows is not counted but is part of the interval; the
  // count saturates at the threshold so a late step cannot wrap it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if (!run) begin
      timer <= '0;
    end else if (issue) begin
      timer <= ONE;
    end else if (count_en && (timer < limit_m1)) begin
      timer <= timer + ONE;
    end
  end

endmodule

// File: rtl/silife_sequencer.sv
// Controller in front of the silife cell matrix: fires generation steps from
// the timer or a manual request, serialises host row writes against steps on
// the matrix read/write port, scans rows out on the read-only port and counts
// generations.
//
// Host handshake: a row write transfers in a cycle where host_valid and
// host_ready are both high; host_row/host_clear/host_set must be stable while
// host_valid is high, and host_ready never depends on host_valid.
module silife_sequencer
  import silife_sequencer_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HEIGHT      = 8,
  parameter int PERIOD_BITS = DEF_PERIOD_BITS,
  parameter int GEN_BITS    = DEF_GEN_BITS,
  parameter int ROW_W       = row_bits(HEIGHT)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   run,
  input  logic                   step,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic [ROW_W-1:0]       host_row,
  input  logic [WIDTH-1:0]       host_clear,
  input  logic [WIDTH-1:0]       host_set,
  output logic [WIDTH-1:0]       host_rdata,
  output logic                   mat_enable,
  output logic [ROW_W-1:0]       mat_row_select,
  output logic [WIDTH-1:0]       mat_clear_cells,
  output logic [WIDTH-1:0]       mat_set_cells,
  input  logic [WIDTH-1:0]       mat_cells,
  output logic [ROW_W-1:0]       mat_row_select2,
  input  logic [WIDTH-1:0]       mat_cells2,
  input  logic                   scan_next,
  output logic [ROW_W-1:0]       scan_row,
  output logic [WIDTH-1:0]       scan_data,
  output logic                   scan_frame,
  output logic                   busy,
  output logic [GEN_BITS-1:0]    generation,
  output seq_state_t             fsm_state
);

  localparam logic [ROW_W-1:0]    LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [ROW_W-1:0]    ROW_ONE  = ROW_W'(1);
  localparam logic [GEN_BITS-1:0] GEN_ONE  = GEN_BITS'(1);

  seq_state_t       state;
  logic             step_pending;
  logic             timer_due;
  logic             due;
  logic             issue;
  logic [ROW_W-1:0] wr_row;

  assign due        = timer_due || step_pending;
  assign issue      = (state == ST_IDLE) && due;
  assign host_ready = reset_n && (state == ST_IDLE) && !due;
  assign fsm_state  = state;

  // Port 1 follows the host row except while a latched write is being applied.
  assign mat_row_select = (state == ST_WRITE) ? wr_row : host_row;
  assign host_rdata     = mat_cells;

  // Port 2 belongs to the scanner alone.
  assign mat_row_select2 = scan_row;
  assign scan_data       = mat_cells2;

  silife_step_timer #(
    .PERIOD_BITS (PERIOD_BITS)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .count_en (state != ST_STEP),
    .issue    (issue),
    .period   (period),
    .due      (timer_due)
  );

  // Manual step request: held until the step fires; pulses arriving while
  // pending or during the STEP cycle fold into that same step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_pending <= 1'b0;
    end else if (state == ST_STEP) begin
      step_pending <= 1'b0;
    end else if (step) begin
      step_pending <= 1'b1;
    end
  end

  // Sequencer FSM: steps take priority over host writes; every matrix strobe
  // is registered and lasts exactly one cycle, so enable and masks never overlap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      wr_row          <= '0;
      mat_enable      <= 1'b0;
      mat_clear_cells <= '0;
      mat_set_cells   <= '0;
      busy            <= 1'b0;
      generation      <= '0;
    end else begin
      mat_enable      <= 1'b0;
      mat_clear_cells <= '0;
      mat_set_cells   <= '0;
      case (state)
        ST_IDLE: begin
          if (due) begin
            state      <= ST_STEP;
            mat_enable <= 1'b1;
            busy       <= 1'b1;
          end else if (host_valid) begin
            state           <= ST_WRITE;
            wr_row          <= host_row;
            mat_clear_cells <= host_clear;
            mat_set_cells   <= host_set;
            busy            <= 1'b1;
          end
        end
        ST_WRITE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        ST_STEP: begin
          // Counted on completion so a reset inside STEP never counts it.
          state      <= ST_IDLE;
          busy       <= 1'b0;
          generation <= generation + GEN_ONE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Row scanner: advances on scan_next and flags the wrap back to row 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_row   <= '0;
      scan_frame <= 1'b0;
    end else begin
      scan_frame <= 1'b0;
      if (scan_next) begin
        if (scan_row == LAST_ROW) begin
          scan_row   <= '0;
          scan_frame <= 1'b1;
        end else begin
          scan_row <= scan_row + ROW_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_silife_sequencer.sv
// Directed bench for silife_sequencer with a behavioural 8x8 cell store
// standing in for the matrix.
module tb_silife_sequencer;
  import silife_sequencer_pkg::*;

  localparam int WIDTH       = 8;
  localparam int HEIGHT      = 8;
  localparam int PERIOD_BITS = 16;
  localparam int GEN_BITS    = 8;
  localparam int ROW_W       = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic                   run;
  logic                   step;
  logic [PERIOD_BITS-1:0] period;
  logic                   host_valid;
  logic                   host_ready;
  logic [ROW_W-1:0]       host_row;
  logic [WIDTH-1:0]       host_clear;
  logic [WIDTH-1:0]       host_set;
  logic [WIDTH-1:0]       host_rdata;
  logic                   mat_enable;
  logic [ROW_W-1:0]       mat_row_select;
  logic [WIDTH-1:0]       mat_clear_cells;
  logic [WIDTH-1:0]       mat_set_cells;
  logic [WIDTH-1:0]       mat_cells;
  logic [ROW_W-1:0]       mat_row_select2;
  logic [WIDTH-1:0]       mat_cells2;
  logic                   scan_next;
  logic [ROW_W-1:0]       scan_row;
  logic [WIDTH-1:0]       scan_data;
  logic                   scan_frame;
  logic                   busy;
  logic [GEN_BITS-1:0]    generation;
  seq_state_t             fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  silife_sequencer #(
    .WIDTH       (WIDTH),
    .HEIGHT      (HEIGHT),
    .PERIOD_BITS (PERIOD_BITS),
    .GEN_BITS    (GEN_BITS)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .run             (run),
    .step            (step),
    .period          (period),
    .host_valid      (host_valid),
    .host_ready      (host_ready),
    .host_row        (host_row),
    .host_clear      (host_clear),
    .host_set        (host_set),
    .host_rdata      (host_rdata),
    .mat_enable      (mat_enable),
    .mat_row_select  (mat_row_select),
    .mat_clear_cells (mat_clear_cells),
    .mat_set_cells   (mat_set_cells),
    .mat_cells       (mat_cells),
    .mat_row_select2 (mat_row_select2),
    .mat_cells2      (mat_cells2),
    .scan_next       (scan_next),
    .scan_row        (scan_row),
    .scan_data       (scan_data),
    .scan_frame      (scan_frame),
    .busy            (busy),
    .generation      (generation),
    .fsm_state       (fsm_state)
  );

  // Behavioural cell store: applies port-1 masks on the clock edge.
  logic [WIDTH-1:0] mem [HEIGHT];
  initial for (int i = 0; i < HEIGHT; i++) mem[i] = '0;
  always @(posedge clk) begin
    if ((mat_clear_cells | mat_set_cells) != '0)
      mem[mat_row_select] <= (mem[mat_row_select] & ~mat_clear_cells) | mat_set_cells;
  end
  assign mat_cells  = mem[mat_row_select];
  assign mat_cells2 = mem[mat_row_select2];

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    run        = 1'b0;
    step       = 1'b0;
    period     = '0;
    host_valid = 1'b0;
    host_row   = '0;
    host_clear = '0;
    host_set   = '0;
    scan_next  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Expected scanner contents after the directed writes below.
  function automatic logic [WIDTH-1:0] exp_row(input int r);
    case (r)
      2:       return 8'h11;
      3:       return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  // Enable and a nonzero mask must never share a cycle.
  always @(negedge clk) begin
    if (reset_n === 1'b1)
      chk("enable_with_mask", {31'b0, mat_enable && ((mat_clear_cells | mat_set_cells) != '0)}, 32'd0);
  end

  initial begin
    // Reset state, with run/period set so a step would be due if not held in reset
    reset_n = 1'b0; run = 1'b1; step = 1'b0; period = 16'd1;
    host_valid = 1'b1; host_row = '0; host_clear = '0; host_set = '0; scan_next = 1'b0;
    tick();
    chk("rst_host_ready", host_ready, 0);
    chk("rst_enable", mat_enable, 0);
    chk("rst_clear", mat_clear_cells, 0);
    chk("rst_set", mat_set_cells, 0);
    chk("rst_busy", busy, 0);
    chk("rst_generation", generation, 0);
    chk("rst_scan_row", scan_row, 0);
    chk("rst_scan_frame", scan_frame, 0);
    chk("rst_state", fsm_state, ST_IDLE);

    // Free-running, period 4: enable on cycles 4, 8, ..., 40
    do_reset();
    period = 16'd4;
    run    = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("t1_enable", mat_enable, (k % 4) == 0);
    end
    run = 1'b0;
    tick();
    chk("t1_generation", generation, 10);
    chk("t1_busy", busy, 0);

    // Three back-to-back step pulses coalesce into one step
    do_reset();
    step = 1'b1;
    tick();
    chk("t2_enable_c1", mat_enable, 0);
    chk("t2_ready_c1", host_ready, 0);
    tick();
    chk("t2_enable_c2", mat_enable, 1);
    chk("t2_busy_c2", busy, 1);
    tick();
    step = 1'b0;
    chk("t2_enable_c3", mat_enable, 0);
    chk("t2_gen_c3", generation, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_enable_after", mat_enable, 0);
    end
    chk("t2_generation", generation, 1);

    // Host row write: accepted in IDLE, applied the next cycle
    host_valid = 1'b1; host_row = 3'd2; host_clear = 8'h00; host_set = 8'h1C;
    #1;
    chk("t3_ready", host_ready, 1);
    tick();
    host_valid = 1'b0;
    chk("t3_row_select", mat_row_select, 2);
    chk("t3_set", mat_set_cells, 8'h1C);
    chk("t3_clear", mat_clear_cells, 8'h00);
    chk("t3_enable", mat_enable, 0);
    chk("t3_busy", busy, 1);
    chk("t3_ready_write", host_ready, 0);
    tick();
    chk("t3_rdata", host_rdata, 8'h1C);
    chk("t3_set_done", mat_set_cells, 8'h00);
    host_valid = 1'b1; host_clear = 8'h0C; host_set = 8'h01;
    tick();
    host_valid = 1'b0;
    tick();
    chk("t3_rdata_clear", host_rdata, 8'h11);
    host_row = 3'd5;
    #1;
    chk("t3_rdata_row5", host_rdata, 8'h00);

    // Timer due and host write in the same IDLE cycle: the step wins
    do_reset();
    period = 16'd3;
    run    = 1'b1;
    tick();
    tick();
    host_valid = 1'b1; host_row = 3'd3; host_clear = 8'h00; host_set = 8'hA5;
    #1;
    chk("t4_ready_blocked", host_ready, 0);
    tick();
    chk("t4_enable", mat_enable, 1);
    chk("t4_set_in_step", mat_set_cells, 8'h00);
    chk("t4_ready_step", host_ready, 0);
    tick();
    chk("t4_enable_off", mat_enable, 0);
    chk("t4_ready_again", host_ready, 1);
    tick();
    host_valid = 1'b0;
    chk("t4_row_select", mat_row_select, 3);
    chk("t4_set", mat_set_cells, 8'hA5);
    chk("t4_enable_write", mat_enable, 0);
    tick();
    chk("t4_enable_c6", mat_enable, 0);
    tick();
    chk("t4_enable_c7", mat_enable, 1);
    run = 1'b0;
    tick();
    tick();
    chk("t4_generation", generation, 2);
    #1;
    chk("t4_rdata", host_rdata, 8'hA5);

    // Period 0: a step every other cycle, then generation wraps
    do_reset();
    period = 16'd0;
    run    = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t5_enable", mat_enable, (k % 2) == 1);
      chk("t5_ready", host_ready, 0);
    end
    chk("t5_gen_10", generation, 5);
    repeat (500) tick();
    chk("t5_gen_max", generation, 8'hFF);
    tick();
    tick();
    chk("t5_gen_wrap", generation, 8'h00);
    run = 1'b0;
    tick();
    tick();

    // Scanner: walks 0..7 and wraps with a one-cycle frame pulse
    do_reset();
    chk("t6_row_start", scan_row, 0);
    chk("t6_frame_start", scan_frame, 0);
    scan_next = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk("t6_row", scan_row, k % 8);
      chk("t6_frame", scan_frame, (k % 8) == 0);
      chk("t6_data", scan_data, exp_row(k % 8));
      chk("t6_row_select2", mat_row_select2, k % 8);
    end
    scan_next = 1'b0;
    tick();
    chk("t6_row_hold", scan_row, 1);
    chk("t6_frame_hold", scan_frame, 0);

    // Reset asserted during WRITE: strobes drop at once, the write never lands
    host_valid = 1'b1; host_row = 3'd4; host_clear = 8'h00; host_set = 8'hF0;
    tick();
    host_valid = 1'b0;
    chk("t7_set_before", mat_set_cells, 8'hF0);
    chk("t7_busy_before", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t7_set_in_reset", mat_set_cells, 8'h00);
    chk("t7_clear_in_reset", mat_clear_cells, 8'h00);
    chk("t7_busy_in_reset", busy, 0);
    chk("t7_ready_in_reset", host_ready, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("t7_busy_after", busy, 0);
    chk("t7_generation_after", generation, 0);
    chk("t7_rdata_row4", host_rdata, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
